// File: rtl/shot_sequencer.sv
// Game-flow controller for one shot: aim, launch, flight and result.
// Also runs the shot clock and keeps the made and attempt counters for display.
module shot_sequencer #(
    parameter int unsigned CLK_HZ            = 100_000_000,
    parameter int unsigned SHOT_SECS         = 24,
    parameter int unsigned DEBOUNCE_CYC      = 1_000_000,
    parameter int unsigned HOOP_X_MIN        = 560,
    parameter int unsigned HOOP_X_MAX        = 600,
    parameter int unsigned HOOP_Y_MIN        = 140,
    parameter int unsigned HOOP_Y_MAX        = 160,
    parameter int unsigned FLOOR_Y           = 470,
    parameter int unsigned SCREEN_W          = 640,
    parameter int unsigned MAX_FLIGHT_FRAMES = 300,
    parameter int unsigned HOLD_FRAMES       = 60
) (
    input  logic        CLK100MHZ,
    input  logic        rst_n,
    input  logic        btn_shoot,
    input  logic        frame_tick,
    input  logic [15:0] ax_in,
    input  logic [15:0] ay_in,
    input  logic [9:0]  ball_x,
    input  logic [9:0]  ball_y,
    output logic        kin_rst,
    output logic        kin_launch,
    output logic [15:0] ax_lat,
    output logic [15:0] ay_lat,
    output logic [2:0]  state,
    output logic [1:0]  result,
    output logic [4:0]  shot_clk,
    output logic [6:0]  score,
    output logic [6:0]  shots
);

    localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned FRM_MAX = (MAX_FLIGHT_FRAMES > HOLD_FRAMES) ? MAX_FLIGHT_FRAMES : HOLD_FRAMES;
    localparam int unsigned FRM_W   = $clog2(FRM_MAX + 1);
    localparam logic [6:0]  CNT_SAT = 7'd99;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_AIM    = 3'd1,
        ST_FLIGHT = 3'd2,
        ST_RESULT = 3'd3,
        ST_VIOL   = 3'd4
    } state_t;

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_MADE = 2'd1;
    localparam logic [1:0] RES_MISS = 2'd2;
    localparam logic [1:0] RES_VIOL = 2'd3;

    logic               r_btn_meta;
    logic               r_btn_sync;
    logic               r_db_level;
    logic               r_db_level_d;
    logic [DB_W-1:0]    r_db_cnt;
    logic               w_shoot_evt;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_kin_rst;
    logic               w_kin_rst_nxt;
    logic               r_kin_launch;
    logic               w_kin_launch_nxt;
    logic [15:0]        r_ax_lat;
    logic [15:0]        w_ax_lat_nxt;
    logic [15:0]        r_ay_lat;
    logic [15:0]        w_ay_lat_nxt;
    logic [1:0]         r_result;
    logic [1:0]         w_result_nxt;
    logic [4:0]         r_shot_clk;
    logic [4:0]         w_shot_clk_nxt;
    logic [6:0]         r_score;
    logic [6:0]         w_score_nxt;
    logic [6:0]         r_shots;
    logic [6:0]         w_shots_nxt;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] w_presc_nxt;
    logic [FRM_W-1:0]   r_frame_cnt;
    logic [FRM_W-1:0]   w_frame_nxt;
    logic [FRM_W-1:0]   w_frame_inc;

    logic               w_in_hoop;
    logic               w_on_floor;
    logic               w_out_bounds;

    // Button synchronizer and level debouncer; the counter tracks consecutive disagreeing samples.
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_meta   <= 1'b0;
            r_btn_sync   <= 1'b0;
            r_db_level   <= 1'b0;
            r_db_level_d <= 1'b0;
            r_db_cnt     <= '0;
        end else begin
            r_btn_meta   <= btn_shoot;
            r_btn_sync   <= r_btn_meta;
            r_db_level_d <= r_db_level;
            if (r_btn_sync == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                r_db_level <= r_btn_sync;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    assign w_shoot_evt = r_db_level & ~r_db_level_d;

    assign w_in_hoop    = (ball_x >= 10'(HOOP_X_MIN)) && (ball_x <= 10'(HOOP_X_MAX)) &&
                          (ball_y >= 10'(HOOP_Y_MIN)) && (ball_y <= 10'(HOOP_Y_MAX));
    assign w_on_floor   = (ball_y >= 10'(FLOOR_Y));
    assign w_out_bounds = (ball_x >= 10'(SCREEN_W - 1)) || (ball_x == 10'd0);
    assign w_frame_inc  = r_frame_cnt + FRM_W'(1);

    // Next-state and next-output logic; every register below is loaded from here.
    always_comb begin
        w_state_nxt      = r_state;
        w_kin_launch_nxt = 1'b0;
        w_ax_lat_nxt     = r_ax_lat;
        w_ay_lat_nxt     = r_ay_lat;
        w_result_nxt     = r_result;
        w_shot_clk_nxt   = r_shot_clk;
        w_score_nxt      = r_score;
        w_shots_nxt      = r_shots;
        w_presc_nxt      = r_presc;
        w_frame_nxt      = r_frame_cnt;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_AIM;
            end
            ST_AIM: begin
                w_ax_lat_nxt = ax_in;
                w_ay_lat_nxt = ay_in;
                // A shot on the same edge as the final shot-clock tick takes precedence.
                if (w_shoot_evt) begin
                    w_state_nxt      = ST_FLIGHT;
                    w_kin_launch_nxt = 1'b1;
                    w_shots_nxt      = (r_shots < CNT_SAT) ? r_shots + 7'd1 : r_shots;
                end else if (r_shot_clk == 5'd0) begin
                    w_state_nxt  = ST_VIOL;
                    w_result_nxt = RES_VIOL;
                end else if (r_presc == PRESC_W'(CLK_HZ - 1)) begin
                    w_presc_nxt    = '0;
                    w_shot_clk_nxt = r_shot_clk - 5'd1;
                    if (r_shot_clk == 5'd1) begin
                        w_state_nxt  = ST_VIOL;
                        w_result_nxt = RES_VIOL;
                    end
                end else begin
                    w_presc_nxt = r_presc + PRESC_W'(1);
                end
            end
            ST_FLIGHT: begin
                if (frame_tick) begin
                    w_frame_nxt = w_frame_inc;
                    if (w_in_hoop) begin
                        w_state_nxt  = ST_RESULT;
                        w_result_nxt = RES_MADE;
                        w_score_nxt  = (r_score < CNT_SAT) ? r_score + 7'd1 : r_score;
                    end else if (w_on_floor || w_out_bounds ||
                                 (w_frame_inc >= FRM_W'(MAX_FLIGHT_FRAMES))) begin
                        w_state_nxt  = ST_RESULT;
                        w_result_nxt = RES_MISS;
                    end
                end
            end
            ST_RESULT, ST_VIOL: begin
                if (frame_tick) begin
                    w_frame_nxt = w_frame_inc;
                    if (w_frame_inc >= FRM_W'(HOLD_FRAMES)) begin
                        w_state_nxt    = ST_AIM;
                        w_result_nxt   = RES_NONE;
                        w_shot_clk_nxt = 5'(SHOT_SECS);
                        w_presc_nxt    = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_state_nxt != r_state) begin
            w_frame_nxt = '0;
        end
        w_kin_rst_nxt = (w_state_nxt != ST_FLIGHT);
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_kin_rst    <= 1'b1;
            r_kin_launch <= 1'b0;
            r_ax_lat     <= '0;
            r_ay_lat     <= '0;
            r_result     <= RES_NONE;
            r_shot_clk   <= 5'(SHOT_SECS);
            r_score      <= '0;
            r_shots      <= '0;
            r_presc      <= '0;
            r_frame_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_kin_rst    <= w_kin_rst_nxt;
            r_kin_launch <= w_kin_launch_nxt;
            r_ax_lat     <= w_ax_lat_nxt;
            r_ay_lat     <= w_ay_lat_nxt;
            r_result     <= w_result_nxt;
            r_shot_clk   <= w_shot_clk_nxt;
            r_score      <= w_score_nxt;
            r_shots      <= w_shots_nxt;
            r_presc      <= w_presc_nxt;
            r_frame_cnt  <= w_frame_nxt;
        end
    end

    assign state      = r_state;
    assign kin_rst    = r_kin_rst;
    assign kin_launch = r_kin_launch;
    assign ax_lat     = r_ax_lat;
    assign ay_lat     = r_ay_lat;
    assign result     = r_result;
    assign shot_clk   = r_shot_clk;
    assign score      = r_score;
    assign shots      = r_shots;

endmodule
